// File: rtl/uart_txd.sv
// UART transmitter: 8 data bits LSB first, optional parity, byte FIFO in front.
// Define UART_TXD_TWO_STOP_EN to send two stop bits per frame.
module uart_txd #(
  parameter logic [15:0] BIT_CLKS   = 16'd864,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       parity_en,
  input  logic       parity_kind,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       txd,
  output logic       busy,
  output logic [4:0] fifo_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);
  localparam logic [16:0] BIT_LAST = {1'b0, BIT_CLKS} - 17'd1;
`ifdef UART_TXD_TWO_STOP_EN
  localparam logic [16:0] STOP_LAST = {BIT_CLKS, 1'b0} - 17'd1;
`else
  localparam logic [16:0] STOP_LAST = BIT_LAST;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    fcnt_q, fcnt_d;
  state_t        state_q, state_d;
  logic [16:0]   bclk_q, bclk_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          rdy_q, rdy_d;
  logic          push, pop;
  logic [7:0]    head;

  assign head      = mem_q[rd_ptr_q];
  assign din_ready = rdy_q;
  assign txd       = txd_q;
  assign busy      = busy_q;
  assign fifo_cnt  = fcnt_q;

  always_comb begin
    push      = din_valid & rdy_q;
    pop       = 1'b0;
    state_d   = state_q;
    bclk_d    = bclk_q + 17'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    txd_d     = txd_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    unique case (state_q)
      S_IDLE: begin
        bclk_d = '0;
        txd_d  = 1'b1;
        pop    = (fcnt_q != 5'd0);
      end
      S_START: begin
        if (bclk_q == BIT_LAST) begin
          bclk_d    = '0;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bclk_q == BIT_LAST) begin
          bclk_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            txd_d   = par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bclk_q == BIT_LAST) begin
          bclk_d  = '0;
          txd_d   = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bclk_q == STOP_LAST) begin
          bclk_d  = '0;
          state_d = S_IDLE;
          pop     = (fcnt_q != 5'd0);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Loading a byte snapshots the parity config for the whole frame.
    if (pop) begin
      state_d   = S_START;
      bclk_d    = '0;
      shift_d   = head;
      par_en_d  = parity_en;
      par_bit_d = parity_kind ^ (^head);
      txd_d     = 1'b0;
      rd_ptr_d  = rd_ptr_q + PW'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    fcnt_d = fcnt_q + {4'd0, push} - {4'd0, pop};
    rdy_d  = (fcnt_d != DEPTH);
    busy_d = (state_d != S_IDLE) | (fcnt_d != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bclk_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      bclk_q    <= bclk_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_uart_txd.sv
// Directed bench for uart_txd with a short bit period.
// Frames are sampled mid-bit and compared against hand-built bit patterns.
module tb_uart_txd;

  localparam int B = 16;
`ifdef UART_TXD_TWO_STOP_EN
  localparam int NS = 2;
`else
  localparam int NS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_kind = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       txd;
  logic       busy;
  logic [4:0] fifo_cnt;

  int asserts = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_txd #(.BIT_CLKS(16'(B)), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .parity_en(parity_en), .parity_kind(parity_kind),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .txd(txd), .busy(busy), .fifo_cnt(fifo_cnt)
  );

  function automatic int flen(input logic pe);
    return 9 + NS + (pe ? 1 : 0);
  endfunction

  function automatic logic [15:0] frame(input logic [7:0] b,
                                        input logic pe,
                                        input logic pk);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
    if (pe) f[9] = pk ^ (^b);
    return f;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    din = b;
    din_valid = 1'b1;
    while (din_ready !== 1'b1 && t < 60*B) begin
      @(negedge clk);
      t++;
    end
    asserts++;
    if (t >= 60*B) begin
      fails++;
      $display("FAIL push_timeout: din_ready=%b, required 1", din_ready);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_fall(output bit ok);
    int t;
    t = 0;
    while (txd !== 1'b0 && t < 40*B) begin
      @(negedge clk);
      t++;
    end
    ok = (txd === 1'b0);
  endtask

  // Called at the first negedge with txd low; runs until busy clears.
  task automatic capture(input int nbits, output logic [63:0] bits,
                         output int blen);
    int e;
    e = 0;
    bits = '1;
    while (busy === 1'b1 && e < 80*B) begin
      if (e % B == B/2 && e / B < nbits) bits[e/B] = txd;
      @(negedge clk);
      e++;
    end
    blen = e;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    asserts++;
    if (txd !== 1'b1) begin
      fails++; $display("FAIL rst_txd: got %b, required 1", txd);
    end
    asserts++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL rst_busy: got %b, required 0", busy);
    end
    asserts++;
    if (din_ready !== 1'b1) begin
      fails++; $display("FAIL rst_ready: got %b, required 1", din_ready);
    end
    asserts++;
    if (fifo_cnt !== 5'd0) begin
      fails++; $display("FAIL rst_cnt: got %0d, required 0", fifo_cnt);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [63:0] bits, exp;
    int blen;
    parity_en = 1'b0;
    push_byte(8'hA5);
    asserts++;
    if (txd !== 1'b1) begin
      fails++; $display("FAIL lat_pre: txd %b, required 1", txd);
    end
    @(negedge clk);
    asserts++;
    if (txd !== 1'b0) begin
      fails++; $display("FAIL lat_fall: txd %b, required 0", txd);
    end
    capture(flen(1'b0), bits, blen);
    exp = '1;
    exp[15:0] = frame(8'hA5, 1'b0, 1'b0);
    asserts++;
    if (bits !== exp) begin
      fails++; $display("FAIL a5_bits: got %h, required %h", bits, exp);
    end
    asserts++;
    if (blen !== flen(1'b0) * B) begin
      fails++;
      $display("FAIL a5_busy_len: got %0d, required %0d", blen, flen(1'b0) * B);
    end
  endtask

  task automatic test_parity;
    logic [63:0] bits, exp;
    int blen;
    bit ok;
    parity_en = 1'b1;
    for (int k = 1; k >= 0; k--) begin
      parity_kind = k[0];
      push_byte(8'h03);
      wait_fall(ok);
      asserts++;
      if (!ok) begin
        fails++; $display("FAIL par_fall: txd %b, required 0", txd);
      end
      capture(flen(1'b1), bits, blen);
      exp = '1;
      exp[15:0] = frame(8'h03, 1'b1, k[0]);
      asserts++;
      if (bits !== exp) begin
        fails++;
        $display("FAIL par_bits kind=%0d: got %h, required %h", k, bits, exp);
      end
      asserts++;
      if (blen !== flen(1'b1) * B) begin
        fails++;
        $display("FAIL par_len kind=%0d: got %0d, required %0d",
                 k, blen, flen(1'b1) * B);
      end
    end
    parity_en = 1'b0;
    parity_kind = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] v [5];
    logic [63:0] bits, exp;
    logic [15:0] fb;
    int blen, pos, fl;
    v = '{8'h3C, 8'h5A, 8'hF0, 8'h0F, 8'h81};
    fl = flen(1'b0);
    parity_en = 1'b0;
    @(negedge clk);
    din = v[0];
    din_valid = 1'b1;
    @(negedge clk);
    din = v[1];
    @(negedge clk);
    asserts++;
    if (txd !== 1'b0 || fifo_cnt !== 5'd1) begin
      fails++;
      $display("FAIL b2b_first_pop: txd %b cnt %0d, required 0 and 1", txd, fifo_cnt);
    end
    fork
      capture(5 * fl, bits, blen);
      begin
        din = v[2];
        @(negedge clk);
        din = v[3];
        @(negedge clk);
        din = v[4];
        @(negedge clk);
        din = 8'h99;
        asserts++;
        if (din_ready !== 1'b0 || fifo_cnt !== 5'd4) begin
          fails++;
          $display("FAIL b2b_full: ready %b cnt %0d, required 0 and 4", din_ready, fifo_cnt);
        end
        repeat (3) @(negedge clk);
        asserts++;
        if (din_ready !== 1'b0 || fifo_cnt !== 5'd4) begin
          fails++;
          $display("FAIL b2b_stall: ready %b cnt %0d, required 0 and 4", din_ready, fifo_cnt);
        end
        din_valid = 1'b0;
      end
    join
    exp = '1;
    pos = 0;
    for (int i = 0; i < 5; i++) begin
      fb = frame(v[i], 1'b0, 1'b0);
      for (int j = 0; j < fl; j++) exp[pos+j] = fb[j];
      pos += fl;
    end
    asserts++;
    if (bits !== exp) begin
      fails++; $display("FAIL b2b_bits: got %h, required %h", bits, exp);
    end
    asserts++;
    if (blen !== 5 * fl * B) begin
      fails++; $display("FAIL b2b_len: got %0d, required %0d", blen, 5 * fl * B);
    end
  endtask

  task automatic test_cfg_midframe;
    logic [63:0] bits, exp;
    int blen;
    bit ok;
    parity_en = 1'b0;
    parity_kind = 1'b0;
    push_byte(8'h55);
    wait_fall(ok);
    fork
      capture(flen(1'b1), bits, blen);
      begin
        repeat (3*B) @(negedge clk);
        parity_en = 1'b1;
        parity_kind = 1'b1;
      end
    join
    exp = '1;
    exp[15:0] = frame(8'h55, 1'b0, 1'b0);
    asserts++;
    if (!ok || bits !== exp || blen !== flen(1'b0) * B) begin
      fails++;
      $display("FAIL cfg_cur: bits %h len %0d, required %h len %0d",
               bits, blen, exp, flen(1'b0) * B);
    end
    push_byte(8'hAA);
    wait_fall(ok);
    capture(flen(1'b1), bits, blen);
    exp = '1;
    exp[15:0] = frame(8'hAA, 1'b1, 1'b1);
    asserts++;
    if (!ok || bits !== exp || blen !== flen(1'b1) * B) begin
      fails++;
      $display("FAIL cfg_next: bits %h len %0d, required %h len %0d",
               bits, blen, exp, flen(1'b1) * B);
    end
    parity_en = 1'b0;
    parity_kind = 1'b0;
  endtask

  task automatic test_reset_midframe;
    bit ok;
    int bad;
    parity_en = 1'b0;
    push_byte(8'hA5);
    wait_fall(ok);
    push_byte(8'h3C);
    push_byte(8'h5A);
    repeat (4*B + B/2 - 4) @(negedge clk);
    asserts++;
    if (!ok || txd !== 1'b0 || fifo_cnt !== 5'd2) begin
      fails++;
      $display("FAIL mid_pre: txd %b cnt %0d, required 0 and 2", txd, fifo_cnt);
    end
    rst_n = 1'b0;
    #1;
    asserts++;
    if (txd !== 1'b1 || fifo_cnt !== 5'd0 || busy !== 1'b0 || din_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_rst: txd %b cnt %0d busy %b rdy %b, required 1 0 0 1",
               txd, fifo_cnt, busy, din_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30*B) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    asserts++;
    if (bad != 0) begin
      fails++; $display("FAIL mid_residual: %0d active cycles, required 0", bad);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] v [4];
    v = '{8'h11, 8'h22, 8'h33, 8'h44};
    parity_en = 1'b1;
    parity_kind = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) push_byte(v[i]);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          logic [7:0] d;
          logic s, p, st, fr;
          bit ok;
          wait_fall(ok);
          repeat (B/2) @(negedge clk);
          s = txd;
          for (int j = 0; j < 8; j++) begin
            repeat (B) @(negedge clk);
            d[j] = txd;
          end
          repeat (B) @(negedge clk);
          p = txd;
          st = 1'b1;
          for (int j = 0; j < NS; j++) begin
            repeat (B) @(negedge clk);
            st &= txd;
          end
          fr = ok && s == 1'b0 && st && ((^d) ^ p) == 1'b1;
          asserts++;
          if (d !== v[i] || fr !== 1'b1) begin
            fails++;
            $display("FAIL loop_rx%0d: byte %h fr %b, required %h fr 1", i, d, fr, v[i]);
          end
        end
      end
    join
    repeat (2*B) @(negedge clk);
    parity_en = 1'b0;
    parity_kind = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_back_to_back;
    test_cfg_midframe;
    test_reset_midframe;
    test_loopback;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
